// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL RESETB, qualifies LOCK and sequences the downstream reset.
// Optional macro PLL_LOCK_SUP_DEGLITCH_EN requires 4 consecutive lock-low cycles in RUN before loss.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int STABLE_CYCLES    = 1024,
  parameter int CNT_W            = 8
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             force_relock,
  input  logic             clear_count,
  output logic             pll_resetb,
  output logic             sys_reset_n,
  output logic             ready,
  output logic             lock_lost,
  output logic             timeout,
  output logic [CNT_W-1:0] relock_count
);

  localparam int MAX_AB = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int TMR_W  = $clog2(MAX_P) + 1;

  localparam logic [TMR_W-1:0] RST_LIM = TMR_W'(PLL_RESET_CYCLES);
  localparam logic [TMR_W-1:0] TO_LIM  = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] STB_LIM = TMR_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d, timer_inc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   loss;
  logic                   lock_lost_d, timeout_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pll_resetb_q, sys_reset_n_q, ready_q, lock_lost_q, timeout_q;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign timer_inc = timer_q + 1'b1;

`ifdef PLL_LOCK_SUP_DEGLITCH_EN
  logic [1:0] dg_q, dg_d;
  assign loss = !lock_s && (dg_q == 2'd3);
`else
  assign loss = !lock_s;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    lock_lost_d = 1'b0;
    timeout_d   = 1'b0;
    count_d     = count_q;
`ifdef PLL_LOCK_SUP_DEGLITCH_EN
    dg_d        = 2'd0;
`endif
    unique case (state_q)
      S_RESET_PLL: begin
        if (timer_inc == RST_LIM) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_LOCK: begin
        timer_d = '0;
        if (force_relock) begin
          state_d = S_RESET_PLL;
        end else if (lock_s) begin
          state_d = S_STABLE;
        end else if (timer_inc == TO_LIM) begin
          state_d   = S_RESET_PLL;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_STABLE: begin
        timer_d = '0;
        if (force_relock) begin
          state_d = S_RESET_PLL;
        end else if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (timer_inc == STB_LIM) begin
          state_d = S_RUN;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RUN: begin
        timer_d = '0;
        if (force_relock) begin
          state_d = S_RESET_PLL;
        end else if (loss) begin
          state_d     = S_RESET_PLL;
          lock_lost_d = 1'b1;
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
        end else begin
`ifdef PLL_LOCK_SUP_DEGLITCH_EN
          dg_d = lock_s ? 2'd0 : dg_q + 2'd1;
`endif
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        timer_d = '0;
      end
    endcase
    // Clearing takes precedence over a same-cycle increment.
    if (clear_count) count_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      state_q       <= S_RESET_PLL;
      timer_q       <= '0;
      count_q       <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], locked};
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      // Outputs decode the next state so they switch on the edge that enters/leaves it.
      pll_resetb_q  <= (state_d != S_RESET_PLL);
      sys_reset_n_q <= (state_d == S_RUN);
      ready_q       <= (state_d == S_RUN);
      lock_lost_q   <= lock_lost_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef PLL_LOCK_SUP_DEGLITCH_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) dg_q <= 2'd0;
    else          dg_q <= dg_d;
  end
`endif

  assign pll_resetb   = pll_resetb_q;
  assign sys_reset_n  = sys_reset_n_q;
  assign ready        = ready_q;
  assign lock_lost    = lock_lost_q;
  assign timeout      = timeout_q;
  assign relock_count = count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued with a target cycle
// when stimulus is driven and compared when the run reaches that cycle.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int SYNC_STAGES      = 2;
  localparam int PLL_RESET_CYCLES = 4;
  localparam int LOCK_TIMEOUT     = 32;
  localparam int STABLE_CYCLES    = 8;
  localparam int CNT_W            = 2;
`ifdef PLL_LOCK_SUP_DEGLITCH_EN
  localparam int DG = 3;
`else
  localparam int DG = 0;
`endif
  // locked fall (driven after edge P) -> RESET_PLL entry at edge P + LOSS_LAT
  localparam int LOSS_LAT = SYNC_STAGES + 1 + DG;
  // locked rise at RESET_PLL entry -> RUN entry
  localparam int RELOCK_LAT = PLL_RESET_CYCLES + 1 + STABLE_CYCLES;

  typedef enum int {SIG_RESETB, SIG_SYSRST, SIG_READY, SIG_LOST, SIG_TO, SIG_CNT} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_total;
  int   n_pass;
  int   exp_cnt;

  logic             clock_in = 1'b0;
  logic             reset_n = 1'b0;
  logic             locked = 1'b0;
  logic             force_relock = 1'b0;
  logic             clear_count = 1'b0;
  logic             pll_resetb, sys_reset_n, ready, lock_lost, timeout;
  logic [CNT_W-1:0] relock_count;

  pll_lock_supervisor #(
    .SYNC_STAGES     (SYNC_STAGES),
    .PLL_RESET_CYCLES(PLL_RESET_CYCLES),
    .LOCK_TIMEOUT    (LOCK_TIMEOUT),
    .STABLE_CYCLES   (STABLE_CYCLES),
    .CNT_W           (CNT_W)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .locked      (locked),
    .force_relock(force_relock),
    .clear_count (clear_count),
    .pll_resetb  (pll_resetb),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .timeout     (timeout),
    .relock_count(relock_count)
  );

  always #5 clock_in = ~clock_in;

  function automatic logic [31:0] observe(sig_e s);
    logic [31:0] v;
    v = '0;
    case (s)
      SIG_RESETB: v = {31'd0, pll_resetb};
      SIG_SYSRST: v = {31'd0, sys_reset_n};
      SIG_READY:  v = {31'd0, ready};
      SIG_LOST:   v = {31'd0, lock_lost};
      SIG_TO:     v = {31'd0, timeout};
      SIG_CNT:    v = {30'd0, relock_count};
      default:    v = 'x;
    endcase
    return v;
  endfunction

  function automatic void sb_push(int d, sig_e s, int v, string n);
    exp_t e;
    e.cyc  = cyc + d;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endfunction

  // Advance n rising edges; after each, at the falling edge, retire due expectations.
  task automatic run_cycles(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock_in);
      cyc++;
      @(negedge clock_in);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_total++;
          if (observe(sb[i].sig) !== sb[i].val)
            $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                     sb[i].name, cyc, observe(sb[i].sig), sb[i].val);
          else
            n_pass++;
          sb.delete(i);
        end
      end
    end
  endtask

  // Holds reset for two cycles, checks reset values, releases at a falling edge.
  task automatic do_reset(string tag);
    logic [6:0] got;
    reset_n = 1'b0;
    run_cycles(2);
    got = {pll_resetb, sys_reset_n, ready, lock_lost, timeout, relock_count};
    n_total++;
    if (got !== 7'd0) $display("FAIL %s_reset_values: got %b, expected 0000000", tag, got);
    else n_pass++;
    reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    locked = 1'b0;
    do_reset("por");
  endtask

  task automatic test_lock_acquire();
    locked = 1'b0;
    do_reset("acq");
    sb_push(3,  SIG_RESETB, 0, "acq_resetb_low");
    sb_push(4,  SIG_RESETB, 1, "acq_resetb_high");
    sb_push(20, SIG_READY,  0, "acq_ready_early");
    sb_push(20, SIG_SYSRST, 0, "acq_sysrst_early");
    sb_push(21, SIG_READY,  1, "acq_ready");
    sb_push(21, SIG_SYSRST, 1, "acq_sysrst");
    sb_push(21, SIG_CNT,    0, "acq_count");
    run_cycles(10);
    locked = 1'b1;
    run_cycles(12);
  endtask

  // From RUN: drop lock until the qualified loss, then re-lock and return to RUN.
  task automatic lose_and_relock(string tag);
    locked = 1'b0;
    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    sb_push(LOSS_LAT - 1, SIG_READY,  1, {tag, "_ready_before"});
    sb_push(LOSS_LAT - 1, SIG_LOST,   0, {tag, "_lost_before"});
    sb_push(LOSS_LAT,     SIG_LOST,   1, {tag, "_lost_pulse"});
    sb_push(LOSS_LAT,     SIG_READY,  0, {tag, "_ready_drop"});
    sb_push(LOSS_LAT,     SIG_RESETB, 0, {tag, "_resetb_drop"});
    sb_push(LOSS_LAT,     SIG_CNT,    exp_cnt, {tag, "_count"});
    sb_push(LOSS_LAT + 1, SIG_LOST,   0, {tag, "_lost_after"});
    run_cycles(LOSS_LAT);
    locked = 1'b1;
    sb_push(RELOCK_LAT - 1, SIG_READY, 0, {tag, "_relock_early"});
    sb_push(RELOCK_LAT,     SIG_READY, 1, {tag, "_relock_ready"});
    run_cycles(RELOCK_LAT);
  endtask

  task automatic test_relock_count();
    for (int k = 0; k < 5; k++) lose_and_relock($sformatf("loss%0d", k));
    clear_count = 1'b1;
    sb_push(1, SIG_CNT, 0, "clear_count");
    run_cycles(1);
    clear_count = 1'b0;
    // Increment and clear land on the same edge: clear wins.
    locked = 1'b0;
    run_cycles(LOSS_LAT - 1);
    clear_count = 1'b1;
    sb_push(1, SIG_LOST, 1, "clr_vs_inc_lost");
    sb_push(1, SIG_CNT,  0, "clr_vs_inc_count");
    run_cycles(1);
    clear_count = 1'b0;
    locked = 1'b1;
    exp_cnt = 0;
    sb_push(RELOCK_LAT, SIG_READY, 1, "clr_vs_inc_relock");
    run_cycles(RELOCK_LAT);
  endtask

  task automatic test_glitch();
    locked = 1'b0;
`ifdef PLL_LOCK_SUP_DEGLITCH_EN
    for (int d = 3; d <= 7; d++) begin
      sb_push(d, SIG_READY, 1, $sformatf("glitch_ready_held%0d", d));
      sb_push(d, SIG_LOST,  0, $sformatf("glitch_no_lost%0d", d));
    end
    sb_push(7, SIG_CNT, exp_cnt, "glitch_count_held");
    run_cycles(2);
    locked = 1'b1;
    run_cycles(6);
`else
    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    sb_push(2,  SIG_SYSRST, 1, "glitch_sysrst_before");
    sb_push(3,  SIG_SYSRST, 0, "glitch_sysrst_drop");
    sb_push(3,  SIG_LOST,   1, "glitch_lost_pulse");
    sb_push(3,  SIG_CNT,    exp_cnt, "glitch_count");
    sb_push(4,  SIG_LOST,   0, "glitch_lost_after");
    sb_push(15, SIG_READY,  0, "glitch_relock_early");
    sb_push(16, SIG_READY,  1, "glitch_relock_ready");
    run_cycles(2);
    locked = 1'b1;
    run_cycles(15);
`endif
  endtask

  task automatic test_force_relock();
    logic [6:0] got;
    lose_and_relock("pre_force");
    locked = 1'b0;
    run_cycles(LOSS_LAT - 1);
    force_relock = 1'b1;
    sb_push(1, SIG_LOST,   0, "force_no_lost");
    sb_push(1, SIG_CNT,    exp_cnt, "force_no_count");
    sb_push(1, SIG_READY,  0, "force_ready_drop");
    sb_push(1, SIG_RESETB, 0, "force_resetb_drop");
    sb_push(1, SIG_SYSRST, 0, "force_sysrst_drop");
    run_cycles(1);
    force_relock = 1'b0;
    locked = 1'b1;
    sb_push(4, SIG_RESETB, 1, "force_wait_lock");
    run_cycles(7);
    // Mid-STABLE: reset must act between clock edges.
    #1 reset_n = 1'b0;
    #1;
    got = {pll_resetb, sys_reset_n, ready, lock_lost, timeout, relock_count};
    n_total++;
    if (got !== 7'd0) $display("FAIL async_reset_outputs: got %b, expected 0000000", got);
    else n_pass++;
    do_reset("mid_stable");
    // Full RESET_PLL period; force_relock is ignored while in it.
    sb_push(3,  SIG_RESETB, 0, "post_reset_resetb_low");
    sb_push(4,  SIG_RESETB, 1, "post_reset_resetb_high");
    sb_push(4,  SIG_CNT,    0, "post_reset_count");
    sb_push(13, SIG_READY,  1, "post_reset_ready");
    run_cycles(1);
    force_relock = 1'b1;
    run_cycles(1);
    force_relock = 1'b0;
    run_cycles(12);
  endtask

  task automatic test_timeout();
    locked = 1'b0;
    do_reset("to");
    sb_push(35, SIG_TO,     0, "to_before");
    sb_push(35, SIG_RESETB, 1, "to_resetb_before");
    sb_push(36, SIG_TO,     1, "to_pulse1");
    sb_push(36, SIG_RESETB, 0, "to_resetb_drop");
    sb_push(37, SIG_TO,     0, "to_after1");
    sb_push(39, SIG_RESETB, 0, "to_resetb_hold");
    sb_push(40, SIG_RESETB, 1, "to_resetb_release");
    sb_push(71, SIG_TO,     0, "to_before2");
    sb_push(72, SIG_TO,     1, "to_pulse2");
    sb_push(73, SIG_TO,     0, "to_after2");
    run_cycles(74);
  endtask

  task automatic test_stable_glitch();
    locked = 1'b1;
    do_reset("stb");
    sb_push(13, SIG_READY,  0, "stb_no_early_run");
    sb_push(21, SIG_READY,  0, "stb_ready_early");
    sb_push(22, SIG_READY,  1, "stb_ready");
    sb_push(22, SIG_SYSRST, 1, "stb_sysrst");
    run_cycles(10);
    locked = 1'b0;
    run_cycles(1);
    locked = 1'b1;
    run_cycles(12);
  endtask

  initial begin
    cyc = 0;
    n_total = 0;
    n_pass = 0;
    exp_cnt = 0;
    test_reset();
    test_lock_acquire();
    test_relock_count();
    test_glitch();
    test_force_relock();
    test_timeout();
    test_stable_glitch();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises a PLL from the far side of its lock interface. Drives the PLL's active-low `RESETB` and consumes its asynchronous `LOCK`. Holds the downstream system in reset until lock has been stable for a programmable time. On lock loss or lock timeout, it re-resets the PLL and retries. Runs on the free-running reference clock (the PLL input), never on a PLL output, so it keeps running while the PLL is held in reset.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `locked` (≥2)
- `PLL_RESET_CYCLES`, 16: cycles `pll_resetb` held low per attempt (≥1)
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before retry (≥1)
- `STABLE_CYCLES`, 1024: consecutive synced-lock cycles required before release (≥1)
- `CNT_W`, 8: width of `relock_count`

Ports (one clock; reset is asynchronous and active-low):
- `clock_in`, in, 1: reference clock
- `reset_n`, in, 1: async active-low reset
- `locked`, in, 1: PLL `LOCK`, asynchronous to `clock_in`
- `force_relock`, in, 1: sync pulse; restarts the PLL from any state except RESET_PLL
- `clear_count`, in, 1: sync; zeroes `relock_count`
- `pll_resetb`, out, 1: to PLL `RESETB`
- `sys_reset_n`, out, 1: downstream reset, low until lock is qualified
- `ready`, out, 1: high only in RUN
- `lock_lost`, out, 1: one-cycle pulse on qualified lock loss in RUN
- `timeout`, out, 1: one-cycle pulse on WAIT_LOCK expiry
- `relock_count`, out, CNT_W: saturating count of lock losses in RUN

## Operation
- `locked` passes through `SYNC_STAGES` flops to give `lock_s`. No other logic touches raw `locked`.
- FSM states: RESET_PLL → WAIT_LOCK → STABLE → RUN.
  - **RESET_PLL:** `pll_resetb` = 0. Stays for exactly `PLL_RESET_CYCLES` cycles, then goes to WAIT_LOCK.
  - **WAIT_LOCK:** timer counts cycles.
    - `lock_s` = 1 → STABLE.
    - Timer reaches `LOCK_TIMEOUT` with no lock → pulse `timeout` and go to RESET_PLL.
  - **STABLE:** counter is cleared on entry and increments while `lock_s` = 1.
    - `lock_s` = 0 → WAIT_LOCK. The timer restarts from 0.
    - `lock_s` = 1 for `STABLE_CYCLES` consecutive cycles → RUN.
  - **RUN:** `sys_reset_n` = 1 and `ready` = 1.
    - Qualified lock loss → pulse `lock_lost`, increment `relock_count` (saturating at all-ones), go to RESET_PLL.
- `force_relock` in WAIT_LOCK, STABLE or RUN → RESET_PLL. It does not count and does not pulse `lock_lost`. It is ignored in RESET_PLL.
- Priority within a cycle: `force_relock` > lock loss / timeout > normal progression.
- `clear_count` and a count increment in the same cycle → result is 0 (clear wins).
- Timers are sized as clog2(max param)+1 bits. No wrap is possible; comparisons are exact.

## Timing
- Reset values (while `reset_n` is low):
  - state = RESET_PLL, timers = 0
  - `pll_resetb` = 0, `sys_reset_n` = 0, `ready` = 0
  - `lock_lost` = 0, `timeout` = 0, `relock_count` = 0
  - synchronizer flops = 0
- Reset assertion mid-operation: all outputs reach their reset values immediately and asynchronously. After release, a full RESET_PLL period runs.
- All outputs are registered and change on the `clock_in` rising edge that enters or leaves the relevant state.
- `locked` rising → earliest `sys_reset_n` high: `SYNC_STAGES` + 1 + `STABLE_CYCLES` edges.
- `locked` falling in RUN → `sys_reset_n`/`ready` low and `pll_resetb` low: `SYNC_STAGES` + 1 edges (plus the deglitch delay if enabled).
- `lock_lost` and `timeout` are high for exactly one cycle, coincident with entry to RESET_PLL.

## Configuration
- `PLL_LOCK_SUP_DEGLITCH_EN`
  - **Defined:** in RUN, `lock_s` must be 0 for 4 consecutive cycles before loss is qualified. Shorter drops are ignored and the deglitch counter clears on any `lock_s` = 1. Loss latency grows by 3 cycles.
  - **Undefined:** a single cycle of `lock_s` = 0 in RUN is a qualified loss.

## Test plan
Parameters: `SYNC_STAGES`=2, `PLL_RESET_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `CNT_W`=2.
- Release `reset_n`, raise `locked` at cycle 10 → `pll_resetb` high after 4 cycles; `sys_reset_n` and `ready` high at cycle 10+2+1+8 = 21; `relock_count` = 0.
- Keep `locked` low → `timeout` pulses 32 cycles after WAIT_LOCK entry, then `pll_resetb` low for 4 cycles; repeats every 36 cycles.
- In STABLE, drop `locked` for 1 cycle at stable count 5 → back to WAIT_LOCK; the full 8-cycle qualification restarts and `ready` is delayed accordingly.
- In RUN, drop `locked` 5 times, re-locking each time → `lock_lost` pulses 5 times; `relock_count` saturates at 3; `clear_count` returns it to 0.
- In RUN, 2-cycle `locked` glitch → with DEGLITCH_EN: no response; without it: `lock_lost` pulses and `sys_reset_n` falls 3 edges after the `locked` fall.
- Assert `force_relock` in RUN in the same cycle as a qualified loss, then assert `reset_n` low mid-STABLE → RESET_PLL entered with no count and no `lock_lost`; async reset drives all outputs to reset values immediately.
